// File: rtl/bist_controller.sv
// BIST sequencer: flushes a four-input benchmark, streams LFSR patterns into it,
// and folds its single output into a CRC-CCITT signature checked against a golden value.
module bist_controller #(
   parameter int unsigned  PAT_COUNT    = 64,
   parameter int unsigned  FLUSH_CYCLES = 4,
   parameter logic [3:0]   FLUSH_VEC    = 4'b0000,
   parameter logic [3:0]   LFSR_SEED    = 4'b0001,
   parameter logic [15:0]  GOLDEN_SIG   = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        dut_out,
   output logic [3:0]  dut_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature,
   output logic [15:0] pat_idx,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 0001.
   localparam logic [3:0]  SEED       = (LFSR_SEED == 4'd0) ? 4'd1 : LFSR_SEED;
   localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
   localparam logic [15:0] PAT_LAST   = 16'(PAT_COUNT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [3:0]  lfsr, lfsr_nxt, lfsr_adv;
   logic [3:0]  dut_in_nxt;
   logic        busy_nxt, done_nxt, pass_nxt, fb;
   logic [15:0] sig_nxt, sig_cap, idx_nxt;

   assign fsm_state = state;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         lfsr      <= 4'd0;
         dut_in    <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         signature <= 16'd0;
         pat_idx   <= 16'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lfsr      <= lfsr_nxt;
         dut_in    <= dut_in_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         signature <= sig_nxt;
         pat_idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      lfsr_nxt   = lfsr;
      dut_in_nxt = dut_in;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      pass_nxt   = pass;
      sig_nxt    = signature;
      idx_nxt    = pat_idx;
      lfsr_adv   = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      fb         = signature[15] ^ dut_out;
      sig_cap    = {signature[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = FLUSH;
               dut_in_nxt = FLUSH_VEC;
               cnt_nxt    = 8'd0;
               sig_nxt    = 16'd0;
               pass_nxt   = 1'b0;
               busy_nxt   = 1'b1;
            end
         end
         FLUSH: begin
            if (abort) begin
               state_nxt  = IDLE;
               dut_in_nxt = 4'd0;
               busy_nxt   = 1'b0;
               pass_nxt   = 1'b0;
            end else begin
               cnt_nxt = cnt + 8'd1;
               if (cnt == FLUSH_LAST) begin
                  state_nxt  = RUN;
                  lfsr_nxt   = SEED;
                  dut_in_nxt = SEED;
                  idx_nxt    = 16'd0;
               end
            end
         end
         RUN: begin
            // Abort takes priority even over the final capture.
            if (abort) begin
               state_nxt  = IDLE;
               dut_in_nxt = 4'd0;
               busy_nxt   = 1'b0;
               pass_nxt   = 1'b0;
            end else begin
               sig_nxt    = sig_cap;
               lfsr_nxt   = lfsr_adv;
               dut_in_nxt = lfsr_adv;
               idx_nxt    = pat_idx + 16'd1;
               if (pat_idx == PAT_LAST) begin
                  state_nxt  = DONE;
                  dut_in_nxt = 4'd0;
                  busy_nxt   = 1'b0;
                  done_nxt   = 1'b1;
                  pass_nxt   = (sig_cap == GOLDEN_SIG);
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: directed instances for fixed signatures plus a randomized
// instance checked against a pattern/signature reference model.
module tb_bist_controller;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start_d = 1'b0;
   logic start_r = 1'b0;
   logic abort_r = 1'b0;
   logic dut_out_r = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] exp_q[$];

   logic [3:0]  in_a, in_b, in_c, in_r;
   logic        busy_a, busy_b, busy_c, busy_r;
   logic        done_a, done_b, done_c, done_r;
   logic        pass_a, pass_b, pass_c, pass_r;
   logic [15:0] sig_a, sig_b, sig_c, sig_r;
   logic [15:0] idx_a, idx_b, idx_c, idx_r;
   logic [1:0]  st_a, st_b, st_c, st_r;

   always #5 clock = ~clock;

   bist_controller #(.PAT_COUNT(4), .FLUSH_CYCLES(2), .GOLDEN_SIG(16'h0000)) u_a (
      .clock(clock), .reset_n(reset_n), .start(start_d), .abort(1'b0), .dut_out(1'b0),
      .dut_in(in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .signature(sig_a), .pat_idx(idx_a), .fsm_state(st_a));

   bist_controller #(.PAT_COUNT(2), .FLUSH_CYCLES(2), .GOLDEN_SIG(16'h3063)) u_b (
      .clock(clock), .reset_n(reset_n), .start(start_d), .abort(1'b0), .dut_out(1'b1),
      .dut_in(in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .signature(sig_b), .pat_idx(idx_b), .fsm_state(st_b));

   bist_controller #(.PAT_COUNT(2), .FLUSH_CYCLES(2), .GOLDEN_SIG(16'h3064)) u_c (
      .clock(clock), .reset_n(reset_n), .start(start_d), .abort(1'b0), .dut_out(1'b1),
      .dut_in(in_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .signature(sig_c), .pat_idx(idx_c), .fsm_state(st_c));

   bist_controller #(.PAT_COUNT(16), .FLUSH_CYCLES(3), .LFSR_SEED(4'b0000),
                     .GOLDEN_SIG(16'h0000)) u_r (
      .clock(clock), .reset_n(reset_n), .start(start_r), .abort(abort_r), .dut_out(dut_out_r),
      .dut_in(in_r), .busy(busy_r), .done(done_r), .pass(pass_r),
      .signature(sig_r), .pat_idx(idx_r), .fsm_state(st_r));

   function automatic logic [3:0] lfsr_step(input logic [3:0] l);
      return {l[2:0], l[3] ^ l[2]};
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
      logic f;
      f = s[15] ^ b;
      return {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic chk_zero_r(input string tag);
      chk({tag, "_in"}, in_r, 0);
      chk({tag, "_busy"}, busy_r, 0);
      chk({tag, "_done"}, done_r, 0);
      chk({tag, "_pass"}, pass_r, 0);
      chk({tag, "_sig"}, sig_r, 0);
      chk({tag, "_idx"}, idx_r, 0);
   endtask

   // One test on u_r with random responses; optionally aborted or reset at pattern k.
   task automatic run_r(input int abort_at, input int reset_at);
      logic [3:0]  l;
      logic [3:0]  want;
      logic [15:0] sig;
      logic [15:0] bits;
      bits = 16'($urandom);
      exp_q.delete();
      l = 4'd1;
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(l);
         l = lfsr_step(l);
      end
      sig = 16'd0;
      start_r = 1'b1;
      @(negedge clock);
      start_r = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("flush_busy", busy_r, 1);
         chk("flush_in", in_r, 0);
         chk("flush_sig", sig_r, 0);
         chk("flush_done", done_r, 0);
         @(negedge clock);
      end
      for (int k = 0; k < 16; k++) begin
         want = exp_q.pop_front();
         chk("run_in", in_r, want);
         chk("run_idx", idx_r, k);
         chk("run_busy", busy_r, 1);
         chk("run_sig", sig_r, sig);
         if (k == 15) chk("wrap", in_r, 4'd1);
         dut_out_r = bits[k];
         if (k == reset_at) begin
            reset_n = 1'b0;
            @(negedge clock);
            chk_zero_r("rst");
            reset_n = 1'b1;
            dut_out_r = 1'b0;
            @(negedge clock);
            chk("rst_done", done_r, 0);
            chk("rst_busy", busy_r, 0);
            return;
         end
         if (k == abort_at) begin
            abort_r = 1'b1;
            @(negedge clock);
            abort_r = 1'b0;
            chk("abort_busy", busy_r, 0);
            chk("abort_done", done_r, 0);
            chk("abort_in", in_r, 0);
            chk("abort_pass", pass_r, 0);
            chk("abort_sig", sig_r, sig);
            chk("abort_idx", idx_r, k);
            @(negedge clock);
            chk("abort_done2", done_r, 0);
            chk("abort_sig2", sig_r, sig);
            return;
         end
         sig = crc_step(sig, bits[k]);
         @(negedge clock);
      end
      chk("end_done", done_r, 1);
      chk("end_busy", busy_r, 0);
      chk("end_in", in_r, 0);
      chk("end_sig", sig_r, sig);
      chk("end_pass", pass_r, (sig == 16'h0000));
      chk("end_idx", idx_r, 16);
      @(negedge clock);
      chk("end_done_pulse", done_r, 0);
      chk("end_pass_hold", pass_r, (sig == 16'h0000));
   endtask

   initial begin
      logic [3:0] a_in [8];
      logic       a_busy [8];
      logic       a_done [8];
      a_in   = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd9, 4'd0, 4'd0};
      a_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      a_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      // start asserted during reset must not launch a test
      start_d = 1'b1;
      start_r = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      start_d = 1'b0;
      start_r = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk_zero_r("idle_r");
         chk("idle_a_in", in_a, 0);
         chk("idle_a_busy", busy_a, 0);
         chk("idle_a_sig", sig_a, 0);
         @(negedge clock);
      end

      start_d = 1'b1;
      @(negedge clock);
      start_d = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk("a_in", in_a, a_in[c]);
         chk("a_busy", busy_a, a_busy[c]);
         chk("a_done", done_a, a_done[c]);
         chk("a_sig", sig_a, 0);
         if (c >= 6) chk("a_pass", pass_a, 1);
         if (c == 3) chk("b_sig1", sig_b, 16'h1021);
         if (c == 4) begin
            chk("b_sig2", sig_b, 16'h3063);
            chk("b_done", done_b, 1);
            chk("b_pass", pass_b, 1);
            chk("c_sig2", sig_c, 16'h3063);
            chk("c_done", done_c, 1);
            chk("c_pass", pass_c, 0);
         end
         if (c == 5) begin
            chk("b_done_pulse", done_b, 0);
            chk("b_pass_hold", pass_b, 1);
            chk("c_pass_hold", pass_c, 0);
         end
         @(negedge clock);
      end

      run_r(-1, -1);
      run_r(-1, -1);
      run_r(3, -1);
      run_r(-1, -1);
      run_r(15, -1);
      run_r(-1, -1);
      run_r(0, -1);
      run_r(-1, 7);
      run_r(-1, -1);
      repeat (3) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
